// File: rtl/dot_product_seq_if.sv
// Operand/result handshake bundle for the sequential dot-product controller.
// The slave side belongs to the controller; the master side belongs to the producer/consumer.
interface dot_product_seq_if #(
  parameter int num_elems  = 5,
  parameter int data_width = 2
);
  localparam int cnt_w = $clog2(num_elems + 1);
  localparam int out_w = 2 * data_width + cnt_w;

  logic                            in_valid;
  logic                            in_ready;
  logic [num_elems*data_width-1:0] a_vec;
  logic [num_elems*data_width-1:0] b_vec;
  logic                            out_valid;
  logic                            out_ready;
  logic [out_w-1:0]                outp;
  logic                            busy;
  logic [cnt_w-1:0]                elem_idx;

  modport master (
    output in_valid, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, outp, busy, elem_idx
  );

  modport slave (
    input  in_valid, a_vec, b_vec, out_ready,
    output in_ready, out_valid, outp, busy, elem_idx
  );
endinterface

// File: rtl/dot_product_seq.sv
// Time-multiplexed dot product: captures two packed vectors, runs one MAC per cycle,
// then holds the result on a valid/ready port until it is consumed.
module dot_product_seq #(
  parameter int num_elems  = 5,
  parameter int data_width = 2
) (
  input logic               clock,
  input logic               reset,
  dot_product_seq_if.slave  bus
);
  localparam int cnt_w = $clog2(num_elems + 1);
  localparam int out_w = 2 * data_width + cnt_w;
  localparam logic [cnt_w-1:0] lastIdx = cnt_w'(num_elems - 1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                          r_state;
  logic [num_elems*data_width-1:0] r_aVec;
  logic [num_elems*data_width-1:0] r_bVec;
  logic [out_w-1:0]                r_acc;
  logic [cnt_w-1:0]                r_idx;
  logic                            r_inReady;
  logic                            r_outValid;
  logic [out_w-1:0]                r_outp;
  logic                            r_busy;

  logic [data_width-1:0]   w_aElem;
  logic [data_width-1:0]   w_bElem;
  logic [2*data_width-1:0] w_prod;
  logic [out_w-1:0]        w_accNext;

  assign w_aElem   = r_aVec[r_idx*data_width +: data_width];
  assign w_bElem   = r_bVec[r_idx*data_width +: data_width];
  assign w_prod    = {{data_width{1'b0}}, w_aElem} * {{data_width{1'b0}}, w_bElem};
  assign w_accNext = r_acc + out_w'(w_prod);

  // The final element's sum goes straight into outp so the result is ready the edge MAC ends.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_aVec     <= '0;
      r_bVec     <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_outp     <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_inReady) begin
            r_aVec    <= bus.a_vec;
            r_bVec    <= bus.b_vec;
            r_acc     <= '0;
            r_idx     <= '0;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= MAC;
          end
        end
        MAC: begin
          r_acc <= w_accNext;
          if (r_idx == lastIdx) begin
            r_idx      <= '0;
            r_outp     <= w_accNext;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.outp      = r_outp;
  assign bus.busy      = r_busy;
  assign bus.elem_idx  = r_idx;
endmodule

// File: doc/dot_product_seq.md
Name: dot_product_seq

Overview:
- Sequencing controller for a time-multiplexed dot-product datapath: accepts two packed operand vectors over a valid/ready handshake.
- Steps a single multiply-accumulate unit through one element pair per cycle.
- Presents the result on a valid/ready output port, holding it until the result is consumed.
- Sits between an operand producer (buffer/loader) and the result consumer; replaces a fully parallel dot-product tree when area matters.

Parameters:
- num_elems, 5, number of elements per vector (>= 1)
- data_width, 2, bits per unsigned element (>= 1)
- Derived (localparam): cnt_w = $clog2(num_elems+1), index/counter width
- Derived (localparam): out_w = 2*data_width + cnt_w, result width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand vectors valid
- in_ready  out  1  block can accept operands
- a_vec  in  num_elems*data_width  vector A; element i at bits [i*data_width +: data_width]
- b_vec  in  num_elems*data_width  vector B; same packing as a_vec
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- outp  out  out_w  dot product, unsigned
- busy  out  1  high in MAC or DONE state
- elem_idx  out  cnt_w  index of the element pair being accumulated (debug)

Behaviour:
- Reset: sampled only on a rising clock edge; takes priority over all other inputs.
  - Forces state to IDLE.
  - in_ready=1, out_valid=0, outp=0, busy=0, elem_idx=0.
  - Accumulator and operand registers cleared.
  - Reset asserted mid-MAC or mid-DONE aborts the operation; no result is emitted.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T: capture a_vec/b_vec into internal registers, clear accumulator, set elem_idx=0, go to MAC.
  - Inputs may change after T without effect.
- MAC:
  - in_ready=0, busy=1.
  - Each cycle: acc <= acc + a[elem_idx]*b[elem_idx], zero-extended to out_w; elem_idx increments.
  - Element 0 is accumulated at edge T+1 and element num_elems-1 at edge T+num_elems; state goes to DONE at that same edge.
- DONE:
  - out_valid=1, outp=acc, held stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE, out_valid=0 next cycle, in_ready=1 next cycle.
  - No same-cycle re-accept; a new operation is accepted at the earliest one cycle after the result handshake.
- Latency and throughput:
  - out_valid first asserts in the cycle after edge T+num_elems, i.e. num_elems+1 cycles after operand acceptance when out_ready is held high.
  - Minimum issue interval is num_elems+2 cycles.
- Arithmetic:
  - All values unsigned.
  - Maximum result num_elems*(2^data_width-1)^2 always fits in out_w; no overflow or wrap is possible.
- Output holding: outp keeps its last result after returning to IDLE and is overwritten only when the next result completes (or on reset).
- Ignored inputs: in_valid while not IDLE has no effect; out_ready while not DONE has no effect.
- num_elems=1: MAC lasts exactly one cycle.
- elem_idx reads 0 in IDLE and DONE.

Test Plan:
- Reset: assert reset 2 cycles while in_valid=1 -> in_ready=1, out_valid=0, outp=0, busy=0 throughout; nothing captured.
- Basic op (defaults): a={0,3,3,2,1}, b={2,1,2,3,3} (element 4 down to element 0, i.e. element 0 is a=1,b=3), out_ready=1 -> out_valid rises 6 cycles after acceptance, outp=18 for exactly 1 cycle, then in_ready=1.
- Max values: all elements of a and b =3 -> outp=45 (7'b0101101); no overflow. All elements zero -> outp=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> outp=18 and out_valid held stable. Meanwhile in_valid=1 with new operands -> in_ready=0, operands not captured. Release out_ready -> IDLE, new operands then accepted.
- Reset mid-MAC: assert reset at the 3rd MAC cycle -> next cycle IDLE, out_valid never rises. The following operation with a=b={1,1,1,1,1} yields outp=5 (no stale accumulator).
- Back-to-back: in_valid held high with operand sets yielding 18 then 5 -> two results in order, acceptances 7 cycles apart with out_ready=1.
